// File: rtl/spike_rate_encoder.sv
// Rate-coding spike encoder: each channel intensity is compared against a shared Galois LFSR,
// one channel per cycle, and the resulting spike vector is handed downstream over valid/ready.
module spike_rate_encoder #(
  parameter int unsigned INPUTS     = 32,
  parameter int unsigned PIXEL_BITS = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(INPUTS)-1:0] wr_addr,
  input  logic [PIXEL_BITS-1:0]     wr_data,
  input  logic                      start,
  input  logic [7:0]                n_steps,
  output logic [INPUTS-1:0]         out_spikes,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int unsigned AW = $clog2(INPUTS);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = 9;
  localparam int unsigned LW = 16;
  localparam logic [LW-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PIXEL_BITS-1:0] mem_q [INPUTS];
  logic [LW-1:0]         lfsr_q, lfsr_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [SW-1:0]         step_q, step_d;
  logic [SW-1:0]         nsteps_q, nsteps_d;
  logic [INPUTS-1:0]     shadow_q, shadow_d;
  logic [INPUTS-1:0]     spikes_q, spikes_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  busy_q;

  logic [AW-1:0]         ch_idx_c;
  logic [LW-1:0]         lfsr_next_c;
  logic [SW-1:0]         step_inc_c;
  logic                  spike_bit_c;
  logic                  commit_c;
  logic                  handshake_c;
  logic                  frame_end_c;

  // The GEN cycle after the last channel commits the shadow vector; the LFSR still steps in it.
  assign ch_idx_c    = ch_q[AW-1:0];
  assign commit_c    = (state_q == GEN) && (ch_q == CW'(INPUTS));
  assign spike_bit_c = lfsr_q[PIXEL_BITS-1:0] < mem_q[ch_idx_c];
  assign lfsr_next_c = {1'b0, lfsr_q[LW-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : LW'(0));
  assign handshake_c = (state_q == HOLD) && valid_q && out_ready;
  assign step_inc_c  = step_q + SW'(1);
  assign frame_end_c = (step_inc_c == nsteps_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = GEN;
      GEN:     if (commit_c) state_d = HOLD;
      HOLD:    if (handshake_c) state_d = frame_end_c ? IDLE : GEN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : datapath_next
    lfsr_d   = lfsr_q;
    ch_d     = ch_q;
    step_d   = step_q;
    nsteps_d = nsteps_q;
    shadow_d = shadow_q;
    spikes_d = spikes_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          nsteps_d = (n_steps == 8'd0) ? SW'(256) : SW'(n_steps);
          step_d   = '0;
          ch_d     = '0;
        end
      end
      GEN: begin
        lfsr_d = lfsr_next_c;
        if (commit_c) begin
          spikes_d = shadow_q;
          valid_d  = 1'b1;
        end else begin
          shadow_d[ch_idx_c] = spike_bit_c;
          ch_d               = ch_q + CW'(1);
        end
      end
      HOLD: begin
        if (handshake_c) begin
          step_d  = step_inc_c;
          valid_d = 1'b0;
          ch_d    = '0;
          done_d  = frame_end_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q   <= LFSR_SEED;
      ch_q     <= '0;
      step_q   <= '0;
      nsteps_q <= '0;
      shadow_q <= '0;
      spikes_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      ch_q     <= ch_d;
      step_q   <= step_d;
      nsteps_q <= nsteps_d;
      shadow_q <= shadow_d;
      spikes_q <= spikes_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  // Intensity store is writable only while idle, so a running frame sees a frozen image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < INPUTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if ((state_q == IDLE) && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign out_spikes = spikes_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
